regfile_wb_arbiter: RTL

// Write-port controller for the 32x64 register file. It first clears X0..X30 with a zero-fill sequence after reset,

---
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x64 register file: zero-fills X0..X(NUM_CLR-1) after reset,
// then round-robin arbitrates two writeback requesters onto the single registered write port.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NUM_CLR = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              grant_id,
   output logic              init_done
);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_CLR       = ADDR_W'(NUM_CLR - 1);
   localparam logic [ADDR_W-1:0] HARDWIRED_ZERO = '1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                rr_ptr_q, rr_ptr_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                grant_q, grant_d;
   logic                init_done_q, init_done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_INIT;
         clr_cnt_q   <= '0;
         rr_ptr_q    <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         grant_q     <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         grant_q     <= grant_d;
         init_done_q <= init_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      grant_d     = grant_q;
      init_done_d = init_done_q;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;

      case (state_q)
         S_INIT: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_cnt_q;
            wr_data_d = '0;
            grant_d   = 1'b0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_CLR) begin
               state_d     = S_RUN;
               init_done_d = 1'b1;
            end
         end
         S_RUN: begin
            // A lone valid always wins; on contention rr_ptr picks the requester.
            req0_ready = req0_valid && (!req1_valid || !rr_ptr_q);
            req1_ready = req1_valid && (!req0_valid ||  rr_ptr_q);
            if (req0_ready) begin
               wr_addr_d = req0_addr;
               wr_data_d = req0_data;
               grant_d   = 1'b0;
               rr_ptr_d  = 1'b1;
               wr_en_d   = (req0_addr != HARDWIRED_ZERO);
            end else if (req1_ready) begin
               wr_addr_d = req1_addr;
               wr_data_d = req1_data;
               grant_d   = 1'b1;
               rr_ptr_d  = 1'b0;
               wr_en_d   = (req1_addr != HARDWIRED_ZERO);
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign grant_id  = grant_q;
   assign init_done = init_done_q;

endmodule
